// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 2-flop input synchronizer, mid-bit sampling FSM and
// a one-entry holding register with valid/ready handshake plus error pulses.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       RxD,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [1:0]    sync_q;
  logic          rxs;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          done;
  logic          ferr_d;

  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q;
  logic          ovr_q, ovr_d;

  // Reset asserts asynchronously; release is re-timed to Clock.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], RxD};
  end

  assign rxs = sync_q[1];

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    done     = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        bitidx_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d  = '0;
          bitidx_d = '0;
          state_d  = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d  = '0;
          shift_d  = {rxs, shift_q[7:1]};
          bitidx_d = bitidx_q + 1'b1;
          if (bitidx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxs) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end
      end
      S_BREAK_WAIT: begin
        timer_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A completed byte loads only if the slot is empty or drained this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It consumes the serial line driven by the team's UART transmitter (8N1 frame, LSB first, idle high), recovers bytes by mid-bit sampling on a clock-count bit timer, and presents them through a one-entry holding register with a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); legal range ≥ 4.
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit validation sample.

Ports:
Clock  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); asserts immediately, released synchronously through the design's existing release logic.
RxD  input  1  asynchronous serial line; idle high.
rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  holding register full.
frame_error  output  1  1-cycle pulse: stop bit sampled low.
overrun  output  1  1-cycle pulse: byte completed while holding register full and not being drained.

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, frame_error=0, overrun=0; synchronizer flops=1; state=IDLE; bit timer=0; bit index=0; shift register=0x00.
- Input path: RxD passes through a 2-flop synchronizer (rxs). All decisions use rxs; this adds 2 cycles of input latency.
- Bit timer: counts 0..CLKS_PER_BIT-1. It clears on every state entry and on every sample.
- States:
  - IDLE: rxs=0 → START, timer cleared.
  - START: at timer=HALF_BIT-1, sample rxs. If 0 → DATA (valid start bit); if 1 → IDLE (glitch rejected, no output activity).
  - DATA: at timer=CLKS_PER_BIT-1, sample rxs into shift register MSB and shift right, so bit0 lands in LSB after 8 samples. Bit index increments per sample; after the 8th sample → STOP.
  - STOP: at timer=CLKS_PER_BIT-1, sample rxs.
    - If 1 (good stop): byte goes to the holding logic, then → IDLE.
    - If 0: frame_error pulses next cycle, byte discarded, → BREAK_WAIT.
  - BREAK_WAIT: stay until rxs=1, then → IDLE. This prevents a held-low or break line from restarting frames.
- Holding/handshake:
  - rx_valid rises on the cycle after the good stop sample. It stays high until a cycle with rx_valid & rx_ready.
  - rx_data changes only when a new byte is loaded.
  - Consume with no completion that cycle → rx_valid=0 next cycle.
  - Completion and consume in the same cycle → new byte loaded, rx_valid stays 1, no overrun.
  - Completion while rx_valid=1 and rx_ready=0 → new byte dropped, old byte kept, overrun pulses 1 cycle.
- Latency: from the RxD falling edge at the start of a frame to rx_valid=1 is 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles (±1 for edge alignment).
- Reset mid-frame: all state and outputs return to reset values at once. After release, reception resumes only on the next falling edge seen in IDLE. A partial frame never produces rx_valid.
- rx_ready while rx_valid=0 has no effect.
- frame_error and overrun are never asserted in the same cycle.

Test Plan:
- CLKS_PER_BIT=16. Drive 8N1 byte 0xA5, rx_ready=1 → rx_valid=1 for exactly 1 cycle with rx_data=0xA5, at the latency stated above; no error pulses.
- RxD low for 4 clocks, then high → stays in IDLE via START rejection; rx_valid, frame_error, overrun all stay 0.
- Byte 0x3C with stop bit 0, line held low 40 clocks, then high, then valid byte 0x81 → frame_error 1-cycle pulse; rx_valid stays 0 while the line is low; then 0x81 is received correctly.
- rx_ready=0; bytes 0x11 then 0x22 back-to-back → rx_data=0x11 with rx_valid held; overrun pulses once at completion of 0x22; asserting rx_ready then gives rx_valid=0 next cycle with rx_data still 0x11.
- Completion of 0x55 in the same cycle rx_ready consumes a held 0x44 → rx_data=0x55, rx_valid stays 1, overrun=0.
- Assert reset during DATA of 0xF0, release, then send 0x0F → outputs at reset values during reset; only 0x0F is received.
- Loopback: team transmitter → this block, CLKS_PER_BIT=10416, bytes 0x00, 0xFF, 0x5A → each byte received exactly once, no error pulses.
